// File: rtl/mem_access_unit_if.sv
// Load/store bus bundle between the CPU core side and the data RAM side.
// slave is the access unit's view; master is the core/memory environment.
interface mem_access_unit_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [1:0]  cpu_size;
  logic        cpu_sext;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_busy;
  logic        cpu_done;
  logic [31:0] cpu_rdata;
  logic        cpu_adel;
  logic        cpu_ades;
  logic        cpu_berr;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_size, cpu_sext,
    input  cpu_addr, cpu_wdata,
    output cpu_busy, cpu_done, cpu_rdata,
    output cpu_adel, cpu_ades, cpu_berr,
    output mem_req, mem_we, mem_be,
    output mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_size, cpu_sext,
    output cpu_addr, cpu_wdata,
    input  cpu_busy, cpu_done, cpu_rdata,
    input  cpu_adel, cpu_ades, cpu_berr,
    input  mem_req, mem_we, mem_be,
    input  mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store lane steering, load extension, req/ack handshake with
// misalignment detection and hung-access timeout. Little-endian lanes.
module mem_access_unit #(
  parameter int TIMEOUT_CYC = 16
) (
  input logic             clk,
  input logic             rst_n,
  mem_access_unit_if.slave bus
);

  localparam int CW =
    (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          we_q;
  logic          sext_q;
  logic [1:0]    size_q;
  logic [1:0]    off_q;

  logic          is_byte;
  logic          is_half;
  logic          mis;
  logic [3:0]    be_n;
  logic [31:0]   wd_n;
  logic [7:0]    ld_b;
  logic [15:0]   ld_h;
  logic [31:0]   ld_val;
  logic          to_hit;

  always_comb begin
    is_byte = bus.cpu_size == 2'b00;
    is_half = bus.cpu_size == 2'b01;
    mis     = is_half ? bus.cpu_addr[0]
            : (!is_byte && bus.cpu_addr[1:0] != 2'b00);
    be_n    = 4'hF;
    wd_n    = bus.cpu_wdata;
    unique case (1'b1)
      is_byte: begin
        be_n = 4'b0001 << bus.cpu_addr[1:0];
        wd_n = {4{bus.cpu_wdata[7:0]}};
      end
      is_half: begin
        be_n = 4'b0011 << {bus.cpu_addr[1], 1'b0};
        wd_n = {2{bus.cpu_wdata[15:0]}};
      end
      default: begin
        be_n = 4'hF;
        wd_n = bus.cpu_wdata;
      end
    endcase
  end

  always_comb begin
    ld_b   = bus.mem_rdata[{off_q, 3'b000} +: 8];
    ld_h   = bus.mem_rdata[{off_q[1], 4'b0000} +: 16];
    ld_val = bus.mem_rdata;
    unique case (1'b1)
      size_q == 2'b00:
        ld_val = {{24{sext_q & ld_b[7]}}, ld_b};
      size_q == 2'b01:
        ld_val = {{16{sext_q & ld_h[15]}}, ld_h};
      default:
        ld_val = bus.mem_rdata;
    endcase
  end

  // TIMEOUT_CYC of 0 disables the hung-access check entirely
  assign to_hit = (TIMEOUT_CYC != 0) && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      we_q          <= 1'b0;
      sext_q        <= 1'b0;
      size_q        <= 2'b00;
      off_q         <= 2'b00;
      bus.cpu_busy  <= 1'b0;
      bus.cpu_done  <= 1'b0;
      bus.cpu_rdata <= 32'h0;
      bus.cpu_adel  <= 1'b0;
      bus.cpu_ades  <= 1'b0;
      bus.cpu_berr  <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_be    <= 4'h0;
      bus.mem_addr  <= 32'h0;
      bus.mem_wdata <= 32'h0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.cpu_req) begin
            we_q         <= bus.cpu_we;
            sext_q       <= bus.cpu_sext;
            size_q       <= bus.cpu_size;
            off_q        <= bus.cpu_addr[1:0];
            bus.cpu_busy <= 1'b1;
            if (mis) begin
              state         <= DONE;
              bus.cpu_done  <= 1'b1;
              bus.cpu_adel  <= !bus.cpu_we;
              bus.cpu_ades  <= bus.cpu_we;
              bus.cpu_rdata <= 32'h0;
            end else begin
              state         <= ACCESS;
              cnt           <= '0;
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= bus.cpu_we;
              bus.mem_be    <= be_n;
              bus.mem_addr  <= {bus.cpu_addr[31:2], 2'b00};
              bus.mem_wdata <= bus.cpu_we ? wd_n : 32'h0;
            end
          end
        end
        ACCESS: begin
          if (bus.mem_ack || to_hit) begin
            state         <= DONE;
            bus.cpu_done  <= 1'b1;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_be    <= 4'h0;
            bus.mem_addr  <= 32'h0;
            bus.mem_wdata <= 32'h0;
            if (bus.mem_ack) begin
              if (!we_q) bus.cpu_rdata <= ld_val;
            end else begin
              bus.cpu_berr  <= 1'b1;
              bus.cpu_rdata <= 32'h0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state        <= IDLE;
          bus.cpu_busy <= 1'b0;
          bus.cpu_done <= 1'b0;
          bus.cpu_adel <= 1'b0;
          bus.cpu_ades <= 1'b0;
          bus.cpu_berr <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
